// File: rtl/simple_cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, sequencer states and
// the instruction-format width helpers used to size the instruction port.
package simple_cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LDA   = 4'h1;
    localparam logic [3:0] OP_LDB   = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_ADDI  = 4'h5;
    localparam logic [3:0] OP_SUBI  = 4'h6;
    localparam logic [3:0] OP_AND   = 4'h7;
    localparam logic [3:0] OP_OR    = 4'h8;
    localparam logic [3:0] OP_XOR   = 4'h9;
    localparam logic [3:0] OP_JMP   = 4'hA;
    localparam logic [3:0] OP_JZ    = 4'hB;
    localparam logic [3:0] OP_JC    = 4'hC;
    localparam logic [3:0] OP_OUT   = 4'hD;
    localparam logic [3:0] OP_MOVBA = 4'hE;
    localparam logic [3:0] OP_HLT   = 4'hF;

    // The operand field must hold either an immediate or a jump target.
    function automatic int opr_w(input int data_w, input int pc_w);
        return (data_w > pc_w) ? data_w : pc_w;
    endfunction

    function automatic int instr_w(input int data_w, input int pc_w);
        return 4 + opr_w(data_w, pc_w);
    endfunction

endpackage

// File: rtl/simple_cpu_alu.sv
// Combinational ALU: arithmetic at DATA_W+1 bits so the top bit yields
// carry (add) or borrow (subtract); logic ops always clear carry.
module simple_cpu_alu
    import simple_cpu_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              z,
    output logic              c
);

    logic [DATA_W:0] wide;

    always_comb begin
        wide   = '0;
        result = a;
        c      = 1'b0;
        case (op)
            OP_ADD, OP_ADDI: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[DATA_W-1:0];
                c      = wide[DATA_W];
            end
            OP_SUB, OP_SUBI: begin
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[DATA_W-1:0];
                c      = wide[DATA_W];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: result = a;
        endcase
        z = (result == '0);
    end

endmodule

// File: rtl/simple_cpu_core.sv
// Accumulator CPU core: IDLE/RUN/HALT sequencer, A/B registers, Z/C flags,
// OUT latch and a saturating executed-instruction counter.
module simple_cpu_core
    import simple_cpu_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int PC_W   = 4,
    parameter int CNT_W  = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              step_mode,
    input  logic                              step,
    output logic [PC_W-1:0]                   imem_addr,
    input  logic [instr_w(DATA_W, PC_W)-1:0]  imem_data,
    output logic [DATA_W-1:0]                 out_data,
    output logic                              out_valid,
    output logic                              running,
    output logic                              halted,
    output logic [PC_W-1:0]                   pc,
    output logic [DATA_W-1:0]                 reg_a,
    output logic [DATA_W-1:0]                 reg_b,
    output logic                              flag_z,
    output logic                              flag_c,
    output logic [CNT_W-1:0]                  instr_count
);

    localparam int OPR_W   = opr_w(DATA_W, PC_W);
    localparam int INSTR_W = instr_w(DATA_W, PC_W);

    state_t            state;
    logic [3:0]        opcode;
    logic [OPR_W-1:0]  operand;
    logic [DATA_W-1:0] imm;
    logic [PC_W-1:0]   tgt;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_z;
    logic              alu_c;
    logic              exec;
    logic              unused_operand;

    assign opcode         = imem_data[INSTR_W-1 -: 4];
    assign operand        = imem_data[OPR_W-1:0];
    assign imm            = operand[DATA_W-1:0];
    assign tgt            = operand[PC_W-1:0];
    assign unused_operand = ^operand;

    assign imem_addr = pc;
    assign running   = (state == ST_RUN);
    assign halted    = (state == ST_HALT);
    // In step mode an instruction only retires on the edge carrying a STEP pulse.
    assign exec      = !step_mode || step;
    assign alu_b     = (opcode == OP_ADDI || opcode == OP_SUBI) ? imm : reg_b;

    simple_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (opcode),
        .a      (reg_a),
        .b      (alu_b),
        .result (alu_result),
        .z      (alu_z),
        .c      (alu_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc          <= '0;
            reg_a       <= '0;
            reg_b       <= '0;
            flag_z      <= 1'b0;
            flag_c      <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            instr_count <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        state       <= ST_RUN;
                        pc          <= '0;
                        reg_a       <= '0;
                        reg_b       <= '0;
                        flag_z      <= 1'b0;
                        flag_c      <= 1'b0;
                        instr_count <= '0;
                    end
                end
                ST_RUN: begin
                    if (exec) begin
                        if (instr_count != '1)
                            instr_count <= instr_count + CNT_W'(1);
                        pc <= pc + PC_W'(1);
                        case (opcode)
                            OP_NOP: ;
                            OP_LDA: reg_a <= imm;
                            OP_LDB: reg_b <= imm;
                            OP_ADD, OP_SUB, OP_ADDI, OP_SUBI,
                            OP_AND, OP_OR, OP_XOR: begin
                                reg_a  <= alu_result;
                                flag_z <= alu_z;
                                flag_c <= alu_c;
                            end
                            OP_JMP: pc <= tgt;
                            OP_JZ:  if (flag_z) pc <= tgt;
                            OP_JC:  if (flag_c) pc <= tgt;
                            OP_OUT: begin
                                out_data  <= reg_a;
                                out_valid <= 1'b1;
                            end
                            OP_MOVBA: reg_b <= reg_a;
                            OP_HLT: begin
                                pc    <= pc;
                                state <= ST_HALT;
                            end
                            default: ;
                        endcase
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simple_cpu_core.sv
// Directed bench for simple_cpu_core: a table of single-instruction vectors
// plus hand-written multi-cycle programs on three parameterisations.
module tb_simple_cpu_core;

    logic clk;
    logic rst_n;
    logic start0, start1, start2;
    logic step_mode, step;

    // dut0: DATA_W=4 PC_W=4 CNT_W=8
    logic [3:0]  imem_addr0, out_data0, pc0, a0, b0;
    logic [7:0]  imem_data0, cnt0;
    logic        out_valid0, running0, halted0, z0, c0;
    logic [7:0]  mem0 [16];
    // dut1: DATA_W=4 PC_W=4 CNT_W=4
    logic [3:0]  imem_addr1, out_data1, pc1, a1, b1, cnt1;
    logic [7:0]  imem_data1;
    logic        out_valid1, running1, halted1, z1, c1;
    logic [7:0]  mem1 [16];
    // dut2: DATA_W=8 PC_W=4 CNT_W=8
    logic [3:0]  imem_addr2, pc2;
    logic [7:0]  out_data2, a2, b2, cnt2;
    logic [11:0] imem_data2;
    logic        out_valid2, running2, halted2, z2, c2;
    logic [11:0] mem2 [16];

    int n_cmp = 0;
    int n_err = 0;
    int ov0 = 0;
    int ov2 = 0;

    assign imem_data0 = mem0[imem_addr0];
    assign imem_data1 = mem1[imem_addr1];
    assign imem_data2 = mem2[imem_addr2];

    simple_cpu_core #(.DATA_W(4), .PC_W(4), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .step_mode(step_mode), .step(step),
        .imem_addr(imem_addr0), .imem_data(imem_data0), .out_data(out_data0),
        .out_valid(out_valid0), .running(running0), .halted(halted0), .pc(pc0),
        .reg_a(a0), .reg_b(b0), .flag_z(z0), .flag_c(c0), .instr_count(cnt0)
    );

    simple_cpu_core #(.DATA_W(4), .PC_W(4), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .step_mode(step_mode), .step(step),
        .imem_addr(imem_addr1), .imem_data(imem_data1), .out_data(out_data1),
        .out_valid(out_valid1), .running(running1), .halted(halted1), .pc(pc1),
        .reg_a(a1), .reg_b(b1), .flag_z(z1), .flag_c(c1), .instr_count(cnt1)
    );

    simple_cpu_core #(.DATA_W(8), .PC_W(4), .CNT_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .step_mode(step_mode), .step(step),
        .imem_addr(imem_addr2), .imem_data(imem_data2), .out_data(out_data2),
        .out_valid(out_valid2), .running(running2), .halted(halted2), .pc(pc2),
        .reg_a(a2), .reg_b(b2), .flag_z(z2), .flag_c(c2), .instr_count(cnt2)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] op;
        logic [3:0] imm;
        logic [3:0] a_init;
        logic [3:0] b_init;
        logic [3:0] exp_a;
        logic [3:0] exp_b;
        logic       exp_z;
        logic       exp_c;
        string      name;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample just after the edge; OUT pulses are tallied here.
    task automatic tick();
        @(posedge clk);
        #1;
        ov0 += int'(out_valid0);
        ov2 += int'(out_valid2);
    endtask

    task automatic pulse_start(input int which);
        case (which)
            0: start0 = 1'b1;
            1: start1 = 1'b1;
            default: start2 = 1'b1;
        endcase
        tick();
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
    endtask

    task automatic wait_halt0(input int budget, input string name);
        int n = 0;
        while (!halted0 && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(halted0), 32'd1);
    endtask

    task automatic clear_mem0();
        for (int i = 0; i < 16; i++) mem0[i] = 8'h00;
    endtask

    task automatic load_prog2();
        clear_mem0();
        mem0[0] = 8'h13; mem0[1] = 8'h25; mem0[2] = 8'h30; mem0[3] = 8'h22;
        mem0[4] = 8'h40; mem0[5] = 8'hD0; mem0[6] = 8'hF0;
    endtask

    initial begin
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        step_mode = 1'b0; step = 1'b0;
        clear_mem0();
        for (int i = 0; i < 16; i++) begin
            mem1[i] = 8'h00;
            mem2[i] = 12'h000;
        end

        vecs[0]  = '{4'h3, 4'h0, 4'd9,  4'd8,  4'd1,  4'd8,  1'b0, 1'b1, "add_carry"};
        vecs[1]  = '{4'h3, 4'h0, 4'd8,  4'd8,  4'd0,  4'd8,  1'b1, 1'b1, "add_zero"};
        vecs[2]  = '{4'h4, 4'h0, 4'd3,  4'd5,  4'd14, 4'd5,  1'b0, 1'b1, "sub_borrow"};
        vecs[3]  = '{4'h4, 4'h0, 4'd5,  4'd5,  4'd0,  4'd5,  1'b1, 1'b0, "sub_zero"};
        vecs[4]  = '{4'h5, 4'h2, 4'd7,  4'd0,  4'd9,  4'd0,  1'b0, 1'b0, "addi"};
        vecs[5]  = '{4'h6, 4'h3, 4'd2,  4'd0,  4'd15, 4'd0,  1'b0, 1'b1, "subi_borrow"};
        vecs[6]  = '{4'h7, 4'h0, 4'd12, 4'd10, 4'd8,  4'd10, 1'b0, 1'b0, "and"};
        vecs[7]  = '{4'h7, 4'h0, 4'd12, 4'd3,  4'd0,  4'd3,  1'b1, 1'b0, "and_zero"};
        vecs[8]  = '{4'h8, 4'h0, 4'd5,  4'd10, 4'd15, 4'd10, 1'b0, 1'b0, "or"};
        vecs[9]  = '{4'h9, 4'h0, 4'd6,  4'd6,  4'd0,  4'd6,  1'b1, 1'b0, "xor_zero"};
        vecs[10] = '{4'hE, 4'h0, 4'd9,  4'd3,  4'd9,  4'd9,  1'b0, 1'b0, "movba"};
        vecs[11] = '{4'h0, 4'h0, 4'd4,  4'd1,  4'd4,  4'd1,  1'b0, 1'b0, "nop"};
        vecs[12] = '{4'hB, 4'h0, 4'd4,  4'd1,  4'd4,  4'd1,  1'b0, 1'b0, "jz_not_taken"};

        // Reset values observed mid-cycle while reset is held
        #12;
        check("rst_pc", 32'(pc0), 32'd0);
        check("rst_a", 32'(a0), 32'd0);
        check("rst_b", 32'(b0), 32'd0);
        check("rst_running", 32'(running0), 32'd0);
        check("rst_halted", 32'(halted0), 32'd0);
        check("rst_out", 32'(out_data0), 32'd0);
        check("rst_cnt", 32'(cnt0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Table: LDA a, LDB b, <op imm>, HLT
        for (int v = 0; v < 13; v++) begin
            clear_mem0();
            mem0[0] = {4'h1, vecs[v].a_init};
            mem0[1] = {4'h2, vecs[v].b_init};
            mem0[2] = {vecs[v].op, vecs[v].imm};
            mem0[3] = 8'hF0;
            pulse_start(0);
            wait_halt0(20, {vecs[v].name, "_halt"});
            check({vecs[v].name, "_a"}, 32'(a0), 32'(vecs[v].exp_a));
            check({vecs[v].name, "_b"}, 32'(b0), 32'(vecs[v].exp_b));
            check({vecs[v].name, "_z"}, 32'(z0), 32'(vecs[v].exp_z));
            check({vecs[v].name, "_c"}, 32'(c0), 32'(vecs[v].exp_c));
            check({vecs[v].name, "_pc"}, 32'(pc0), 32'd3);
        end

        // Basic program, run twice, with exact latency
        load_prog2();
        for (int r = 0; r < 2; r++) begin
            ov0 = 0;
            pulse_start(0);
            check("p2_start_pc", 32'(pc0), 32'd0);
            check("p2_start_cnt", 32'(cnt0), 32'd0);
            repeat (6) tick();
            check("p2_running_at6", 32'(running0), 32'd1);
            tick();
            check("p2_halted_at7", 32'(halted0), 32'd1);
            check("p2_a", 32'(a0), 32'd6);
            check("p2_out", 32'(out_data0), 32'd6);
            check("p2_ov_pulses", 32'(ov0), 32'd1);
            check("p2_pc", 32'(pc0), 32'd6);
            check("p2_cnt", 32'(cnt0), 32'd7);
        end

        // Carry-driven branch taken into OUT
        clear_mem0();
        mem0[0] = 8'h1F; mem0[1] = 8'h51; mem0[2] = 8'hC4;
        mem0[3] = 8'hF0; mem0[4] = 8'hD0; mem0[5] = 8'hF0;
        ov0 = 0;
        pulse_start(0);
        wait_halt0(20, "jc_halt");
        check("jc_a", 32'(a0), 32'd0);
        check("jc_z", 32'(z0), 32'd1);
        check("jc_c", 32'(c0), 32'd1);
        check("jc_out", 32'(out_data0), 32'd0);
        check("jc_ov", 32'(ov0), 32'd1);
        check("jc_pc", 32'(pc0), 32'd5);
        check("jc_cnt", 32'(cnt0), 32'd5);

        // Logic op clears a set carry; branches on cleared flags fall through
        clear_mem0();
        mem0[0] = 8'h1F; mem0[1] = 8'h51; mem0[2] = 8'h2F; mem0[3] = 8'h80;
        mem0[4] = 8'hB7; mem0[5] = 8'hC7; mem0[6] = 8'hF0;
        mem0[7] = 8'h15; mem0[8] = 8'hF0;
        pulse_start(0);
        wait_halt0(20, "clr_halt");
        check("clr_a", 32'(a0), 32'd15);
        check("clr_z", 32'(z0), 32'd0);
        check("clr_c", 32'(c0), 32'd0);
        check("clr_pc", 32'(pc0), 32'd6);
        check("clr_cnt", 32'(cnt0), 32'd7);

        // Single-step mode
        load_prog2();
        step_mode = 1'b1;
        pulse_start(0);
        repeat (20) tick();
        check("step_idle_pc", 32'(pc0), 32'd0);
        check("step_idle_a", 32'(a0), 32'd0);
        check("step_idle_cnt", 32'(cnt0), 32'd0);
        repeat (3) pulse_step();
        check("step3_pc", 32'(pc0), 32'd3);
        check("step3_a", 32'(a0), 32'd8);
        repeat (4) pulse_step();
        check("step7_halted", 32'(halted0), 32'd1);
        check("step7_a", 32'(a0), 32'd6);
        pulse_step();
        check("step_in_halt_pc", 32'(pc0), 32'd6);
        check("step_in_halt_cnt", 32'(cnt0), 32'd7);
        // START and STEP together: only the restart happens
        start0 = 1'b1;
        step = 1'b1;
        tick();
        start0 = 1'b0;
        step = 1'b0;
        check("start_step_pc", 32'(pc0), 32'd0);
        check("start_step_a", 32'(a0), 32'd0);
        check("start_step_cnt", 32'(cnt0), 32'd0);
        check("start_step_running", 32'(running0), 32'd1);
        step_mode = 1'b0;
        wait_halt0(20, "freerun_resume_halt");
        check("freerun_resume_a", 32'(a0), 32'd6);
        check("freerun_resume_cnt", 32'(cnt0), 32'd7);

        // PC wraps 15 -> 0 with no implicit halt
        clear_mem0();
        mem0[0] = 8'h51;
        pulse_start(0);
        repeat (17) tick();
        check("wrap_pc", 32'(pc0), 32'd1);
        check("wrap_a", 32'(a0), 32'd2);
        check("wrap_cnt", 32'(cnt0), 32'd17);
        check("wrap_running", 32'(running0), 32'd1);

        // DATA_W=8 arithmetic
        mem2[0] = 12'h1C8; mem2[1] = 12'h564; mem2[2] = 12'hD00;
        mem2[3] = 12'h6FA; mem2[4] = 12'hF00;
        ov2 = 0;
        pulse_start(2);
        repeat (2) tick();
        check("w8_addi_a", 32'(a2), 32'd44);
        check("w8_addi_c", 32'(c2), 32'd1);
        tick();
        check("w8_out", 32'(out_data2), 32'd44);
        check("w8_ov", 32'(ov2), 32'd1);
        tick();
        check("w8_subi_a", 32'(a2), 32'd50);
        check("w8_subi_c", 32'(c2), 32'd1);
        check("w8_subi_z", 32'(z2), 32'd0);
        tick();
        check("w8_halted", 32'(halted2), 32'd1);
        check("w8_pc", 32'(pc2), 32'd4);

        // Counting loop with a 4-bit saturating counter
        mem1[0] = 8'h10; mem1[1] = 8'h51; mem1[2] = 8'hA1;
        pulse_start(1);
        repeat (30) tick();
        check("loop_a15", 32'(a1), 32'd15);
        check("loop_c_before_wrap", 32'(c1), 32'd0);
        repeat (2) tick();
        check("loop_wrap_a", 32'(a1), 32'd0);
        check("loop_wrap_c", 32'(c1), 32'd1);
        check("loop_wrap_z", 32'(z1), 32'd1);
        repeat (8) tick();
        check("loop_a_at40", 32'(a1), 32'd4);
        check("loop_cnt_sat", 32'(cnt1), 32'd15);

        // Asynchronous reset mid-cycle while dut0 and dut1 are running
        #2;
        rst_n = 1'b0;
        #1;
        check("arst1_pc", 32'(pc1), 32'd0);
        check("arst1_a", 32'(a1), 32'd0);
        check("arst1_c", 32'(c1), 32'd0);
        check("arst1_cnt", 32'(cnt1), 32'd0);
        check("arst1_running", 32'(running1), 32'd0);
        check("arst0_pc", 32'(pc0), 32'd0);
        check("arst0_a", 32'(a0), 32'd0);
        check("arst0_out", 32'(out_data0), 32'd0);
        check("arst0_cnt", 32'(cnt0), 32'd0);
        check("arst0_running", 32'(running0), 32'd0);
        check("arst2_halted", 32'(halted2), 32'd0);
        check("arst2_out", 32'(out_data2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/simple_cpu_core.md
Name: simple_cpu_core

Overview:
Parametrised accumulator CPU core. It generalises the fixed 4-bit board CPU in data width, program-counter width and instruction-count width. New capabilities are conditional branching, Z/C flags, an explicit OUT instruction and a single-step mode. Program memory is external and read combinationally. The board top wraps this core and maps buttons to START/STEP and OUT_DATA to the LEDs.

Parameters:
DATA_W, 4, width of A, B, immediates and OUT_DATA
PC_W, 4, program-counter width; program depth is 2**PC_W
CNT_W, 8, width of the saturating executed-instruction counter
(derived) OPR_W = max(DATA_W, PC_W); INSTR_W = 4 + OPR_W

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous, active-low reset
START  in  1  one-cycle pulse; begins execution from address 0
STEP_MODE  in  1  1 = one instruction per STEP pulse
STEP  in  1  one-cycle pulse; advance one instruction when STEP_MODE=1
IMEM_ADDR  out  PC_W  instruction address (equals PC)
IMEM_DATA  in  INSTR_W  instruction; opcode in bits [INSTR_W-1 -: 4], operand in the low OPR_W bits
OUT_DATA  out  DATA_W  last value written by OUT
OUT_VALID  out  1  one-cycle pulse on the edge OUT executes
RUNNING  out  1  state == RUN
HALTED  out  1  state == HALT
PC  out  PC_W  program counter
REG_A  out  DATA_W  accumulator
REG_B  out  DATA_W  B register
FLAG_Z  out  1  zero flag
FLAG_C  out  1  carry / borrow flag
INSTR_COUNT  out  CNT_W  instructions executed since START; saturates at all-ones

Behaviour:
- Reset (async, RST_N=0): state=IDLE; PC, REG_A, REG_B, flags, OUT_DATA, INSTR_COUNT = 0; OUT_VALID=0.
- States:
  - IDLE --START--> RUN.
  - HALT --START--> RUN.
  - RUN --HLT executed--> HALT.
  - Reset from any state --> IDLE.
- On START (IDLE or HALT): PC, A, B, Z, C, INSTR_COUNT cleared; OUT_DATA retained. No instruction executes on the START edge.
- START while in RUN is ignored.
- Execute enable in RUN = !STEP_MODE || STEP. At most one instruction per edge; IMEM_DATA is sampled at that edge.
- Latency: START at edge k; instruction 0 executes at edge k+1. In free-run mode there is one instruction per cycle.
- Opcodes (imm = operand[DATA_W-1:0], tgt = operand[PC_W-1:0]):
  - 0 NOP
  - 1 LDA A<=imm
  - 2 LDB B<=imm
  - 3 ADD A<=A+B
  - 4 SUB A<=A-B
  - 5 ADDI A<=A+imm
  - 6 SUBI A<=A-imm
  - 7 AND A<=A&B
  - 8 OR A<=A|B
  - 9 XOR A<=A^B
  - A JMP PC<=tgt
  - B JZ: if Z, PC<=tgt
  - C JC: if C, PC<=tgt
  - D OUT: OUT_DATA<=A, OUT_VALID=1
  - E MOVBA B<=A
  - F HLT
- Arithmetic is computed at DATA_W+1 bits.
  - ADD/ADDI: C = carry out.
  - SUB/SUBI: C = borrow (1 when minuend < subtrahend).
  - Z = (result == 0). Results wrap modulo 2**DATA_W.
- Logic ops: Z updated, C cleared.
- LDA/LDB/MOVBA/jumps/OUT/NOP: flags unchanged.
- PC for non-taken and non-jump instructions: PC+1, wrapping from 2**PC_W-1 to 0. There is no implicit halt.
- HLT: PC stays at the HLT address; state->HALT; the HLT counts as executed.
- INSTR_COUNT increments once per executed instruction and holds at all-ones.
- STEP while STEP_MODE=0 has no extra effect. STEP in IDLE or HALT is ignored. START and STEP on the same edge in IDLE: START wins and nothing executes.
- STEP_MODE may change at any time; it takes effect on the next edge.
- Reset asserted mid-run: all outputs reach reset values immediately (asynchronous), with no waiting for the clock.

Decomposition:
- simple_cpu_pkg: opcode constants, state encoding (IDLE/RUN/HALT), and the INSTR_W/OPR_W helper function.
- Sub-module simple_cpu_alu: combinational; inputs op, A, operand B/imm; outputs result, Z, C.
- Sequencer, registers and counter stay in simple_cpu_core.

Test Plan:
1. Reset with RST_N=0 mid-cycle -> immediately PC=0, A=B=0, RUNNING=0, HALTED=0, OUT_DATA=0, INSTR_COUNT=0.
2. Program LDA 3, LDB 5, ADD, LDB 2, SUB, OUT, HLT; pulse START -> 7 cycles later A=6, OUT_DATA=6, one OUT_VALID pulse, PC=6, HALTED=1, INSTR_COUNT=7. Pulse START again -> identical result.
3. Program LDA 15, ADDI 1, JC 4, HLT, OUT, HLT -> A=0, Z=1, C=1, branch taken, OUT_DATA=0, halts at PC=5, INSTR_COUNT=5.
4. STEP_MODE=1, program from scenario 2, START, then no STEP for 20 cycles -> PC=0, A=0. Then 3 STEP pulses -> PC=3, A=8. Then 4 more -> HALTED, A=6.
5. Loop LDA 0, ADDI 1, JMP 1 with CNT_W=4, free-running 40 cycles -> A wraps 15->0 with C=1, INSTR_COUNT saturates at 15. Assert RST_N low -> all outputs 0, state IDLE.
6. DATA_W=8, PC_W=4: LDA 200, ADDI 100, OUT, SUBI 250, HLT -> OUT_DATA=44 with C=1 after ADDI. After SUBI: A=50, C=1 (borrow), Z=0.
